md_sequencer: RTL
=================

// Module: md_sequencer
// PURPOSE
//  Sequences the shared HI/LO multiply/divide resource for the 5-stage MIPS pipeline.
//  - Accepts md ops from the EX stage and models the fixed mult and div latencies.
//  - Owns the HI/LO registers.
//  - Raises a stall request for the md instruction currently in ID (ID_is_md_ins)
//    whenever the unit is starting or still busy.
// PARAMETERS
//  MULT_LAT  5   busy cycles for mult/multu (and madd family when enabled); >=1
//  DIV_LAT   10  busy cycles for div/divu; >=1
// PORTS
//  clk        in   1   sole clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  mdop_ex    in   4   md opcode of instruction in EX (0 = none); encoding in md_pkg
//  rs_val_ex  in   32  forwarded rs operand in EX
//  rt_val_ex  in   32  forwarded rt operand in EX
//  id_md_ins  in   1   ID stage holds an md-class instruction (ID_is_md_ins)
//  start      out  1   comb: EX op is mult/multu/div/divu (or madd family)
//  busy       out  1   registered: operation in flight
//  stall_md   out  1   comb: id_md_ins & (start | busy)
//  hi         out  32  HI register
//  lo         out  32  LO register
// BEHAVIOUR
//  - Reset: hi=0, lo=0, busy=0, internal counter=0, state IDLE.
//    Asserting reset mid-operation aborts the op and leaves HI/LO = 0.
//  - FSM states: IDLE, BUSY.
//    IDLE -> BUSY on a start edge: latch the op result; cnt = LAT-1.
//    BUSY: cnt decrements each cycle. At cnt==0 the next edge commits HI/LO, busy=0,
//    and the FSM returns to IDLE.
//  - Timing for start in cycle T: busy=1 in T+1..T+LAT; new HI/LO visible from T+LAT+1.
//  - Arithmetic:
//    mult = signed 32x32->64; multu = unsigned. HI = [63:32], LO = [31:0].
//    div: LO = quotient, HI = remainder. Signed div truncates toward zero;
//    remainder takes the sign of the dividend.
//  - Divide by zero (rt==0): the op still takes DIV_LAT cycles; HI/LO keep their prior values.
//  - mthi/mtlo: write HI/LO at the next edge, no busy. Same cycle readable through mfhi/mflo
//    is NOT provided; the pipeline forwards.
//  - mfhi/mflo: no state change; consumers read the hi/lo ports.
//  - start, mthi or mtlo arriving while busy=1: ignored, with a simulation assertion.
//    stall_md guarantees this cannot occur in a legal pipeline.
//  - stall_md holds from the cycle of start through the last busy cycle.
//    The ID md instruction proceeds in the cycle after busy falls.
//  - Non-md instructions are never stalled by this block.
// CONFIGURATION
//  MD_MADD_EN defined:
//    - Adds madd/maddu/msub/msubu.
//    - {HI,LO} +/- product (signed or unsigned), 64-bit wrap.
//    - Latency MULT_LAT. The accumulator base is the {HI,LO} value at commit time.
//  MD_MADD_EN undefined:
//    - Those opcodes decode as none: start=0, no state change.
// STRUCTURE
//  - md_pkg:
//    - MDOP_* localparams: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6,
//      MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
//    - FSM state encodings.
//  - Sub-module md_arith: combinational 64-bit result from (op, rs, rt, hi, lo).
//    The sequencer registers its output at start and commits it at the end of the op.
// TESTING
//  1. mult with rs=-3 (0xFFFFFFFD), rt=7 -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  2. divu with rs=100, rt=7; id_md_ins=1 throughout
//     -> stall_md=1 for 11 cycles (start + 10 busy); lo=14, hi=2 on the 11th edge.
//  3. div with rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1) after 10 busy cycles.
//  4. div with rt=0 after mthi 0x1234 / mtlo 0x5678 -> busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
//  5. reset asserted at busy cycle 3 of a mult -> busy=0, hi=lo=0 immediately (async);
//     no late commit occurs after reset is released.
//  6. MD_MADD_EN: hi=0, lo=0xFFFFFFFF, maddu rs=1 rt=1 -> hi=1, lo=0 after 5 busy cycles;
//     without the macro: no busy, no change.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds md opcode encodings, FSM state encodings and opcode classifiers.
// Optional feature macro: MD_MADD_EN (madd/maddu/msub/msubu decode).
package md_pkg;

  localparam int MDOP_W = 4;

  localparam logic [MDOP_W-1:0] MDOP_NONE  = 4'd0;
  localparam logic [MDOP_W-1:0] MDOP_MULT  = 4'd1;
  localparam logic [MDOP_W-1:0] MDOP_MULTU = 4'd2;
  localparam logic [MDOP_W-1:0] MDOP_DIV   = 4'd3;
  localparam logic [MDOP_W-1:0] MDOP_DIVU  = 4'd4;
  localparam logic [MDOP_W-1:0] MDOP_MFHI  = 4'd5;
  localparam logic [MDOP_W-1:0] MDOP_MFLO  = 4'd6;
  localparam logic [MDOP_W-1:0] MDOP_MTHI  = 4'd7;
  localparam logic [MDOP_W-1:0] MDOP_MTLO  = 4'd8;
  localparam logic [MDOP_W-1:0] MDOP_MADD  = 4'd9;
  localparam logic [MDOP_W-1:0] MDOP_MADDU = 4'd10;
  localparam logic [MDOP_W-1:0] MDOP_MSUB  = 4'd11;
  localparam logic [MDOP_W-1:0] MDOP_MSUBU = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  // Ops that occupy the unit for the multiply latency.
  function automatic logic md_is_mul_class(input logic [MDOP_W-1:0] op);
    logic r;
    r = (op == MDOP_MULT) || (op == MDOP_MULTU);
`ifdef MD_MADD_EN
    r = r || (op == MDOP_MADD) || (op == MDOP_MADDU) ||
             (op == MDOP_MSUB) || (op == MDOP_MSUBU);
`endif
    return r;
  endfunction

  // Ops that occupy the unit for the divide latency.
  function automatic logic md_is_div_class(input logic [MDOP_W-1:0] op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit {HI,LO} result for one md operation.
// Latency: 0 (pure combinational); no backpressure, the sequencer samples it on start.
// Ports: op (md opcode), rs/rt (operands), hi/lo (current HI/LO), result ({HI,LO} to commit).
// Optional feature macro: MD_MADD_EN (multiply-accumulate family).
module md_arith
  import md_pkg::*;
(
  input  logic [MDOP_W-1:0] op,
  input  logic [31:0]       rs,
  input  logic [31:0]       rt,
  input  logic [31:0]       hi,
  input  logic [31:0]       lo,
  output logic [63:0]       result
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] acc;
  logic [31:0] den_u;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] mag_rs;
  logic [31:0] mag_rt;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic        rt_zero;

  assign rt_zero = (rt == 32'd0);
  assign acc     = {hi, lo};

  // Sign-extending to 64 bits first makes the low 64 bits of the product exact.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Divisor forced non-zero so the divider never produces X; the
  // divide-by-zero result is replaced by the old {HI,LO} below.
  assign den_u = rt_zero ? 32'd1 : rt;
  assign quo_u = rs / den_u;
  assign rem_u = rs % den_u;

  // Signed divide via magnitudes: quotient truncates toward zero and the
  // remainder follows the dividend's sign. 0x80000000 magnitude fits unsigned.
  assign mag_rs  = rs[31] ? (~rs + 32'd1) : rs;
  assign mag_rt  = rt[31] ? (~rt + 32'd1) : den_u;
  assign quo_mag = mag_rs / mag_rt;
  assign rem_mag = mag_rs % mag_rt;
  assign quo_s   = (rs[31] ^ rt[31]) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem_s   = rs[31] ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    result = acc;
    case (op)
      MDOP_MULT:  result = prod_s;
      MDOP_MULTU: result = prod_u;
      MDOP_DIV:   result = rt_zero ? acc : {rem_s, quo_s};
      MDOP_DIVU:  result = rt_zero ? acc : {rem_u, quo_u};
`ifdef MD_MADD_EN
      MDOP_MADD:  result = acc + prod_s;
      MDOP_MADDU: result = acc + prod_u;
      MDOP_MSUB:  result = acc - prod_s;
      MDOP_MSUBU: result = acc - prod_u;
`endif
      default:    result = acc;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Sequences the shared HI/LO multiply/divide unit and owns the HI/LO registers.
// Latency: start in cycle T -> busy T+1..T+LAT, new HI/LO from T+LAT+1; mthi/mtlo land next edge.
// Backpressure: stall_md holds the ID md instruction from the start cycle through the last busy cycle.
// Ports: clk, reset (async active-high), mdop_ex/rs_val_ex/rt_val_ex (EX op + operands),
//        id_md_ins (ID holds md instr), start, busy, stall_md, hi, lo.
// Optional feature macro: MD_MADD_EN (madd/maddu/msub/msubu with MULT_LAT latency).
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MDOP_W-1:0] mdop_ex,
  input  logic [31:0]       rs_val_ex,
  input  logic [31:0]       rt_val_ex,
  input  logic              id_md_ins,
  output logic              start,
  output logic              busy,
  output logic              stall_md,
  output logic [31:0]       hi,
  output logic [31:0]       lo
);

  localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);

  md_state_t   state;
  md_state_t   state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic        load_res;
  logic        commit;
  logic        is_mul;
  logic        is_div;
  logic        mt_op;
  logic [63:0] arith_res;
  logic [63:0] res_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  assign is_mul   = md_is_mul_class(mdop_ex);
  assign is_div   = md_is_div_class(mdop_ex);
  assign mt_op    = (mdop_ex == MDOP_MTHI) || (mdop_ex == MDOP_MTLO);
  assign start    = is_mul || is_div;
  assign busy     = (state == ST_BUSY);
  assign stall_md = id_md_ins && (start || busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

  // HI/LO cannot change while busy, so sampling the accumulator base at
  // start gives the same value as reading it at commit.
  md_arith u_arith (
    .op     (mdop_ex),
    .rs     (rs_val_ex),
    .rt     (rt_val_ex),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (arith_res)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_res  = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_BUSY;
          load_res  = 1'b1;
          cnt_nxt   = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
        end
      end
      ST_BUSY: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_res) res_q <= arith_res;
    end
  end

  // mthi/mtlo are only honoured while idle; a busy-time move is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= res_q[63:32];
      lo_q <= res_q[31:0];
    end else if (state == ST_IDLE) begin
      if (mdop_ex == MDOP_MTHI) hi_q <= rs_val_ex;
      if (mdop_ex == MDOP_MTLO) lo_q <= rs_val_ex;
    end
  end

  // A legal pipeline never issues a start or move into a busy unit.
  a_no_issue_while_busy: assert property (
    @(posedge clk) disable iff (reset) busy |-> !(start || mt_op)
  );

endmodule
